// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. An accepted request loads the ALU operand/control registers,
// the ALU result is captured one cycle later, and the result is returned on
// the owning requester's response channel.
// Optional feature macro: ALU_ARB_PIPE_EN. When it is defined, a new request
// may be accepted in the same cycle that the previous response hands off.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [WIDTH-1:0] alu_ra,
    output logic [WIDTH-1:0] alu_rb,
    output logic             alu_arith_mode,
    output logic             alu_logic_alt,
    output logic [2:0]       alu_funct3,
    input  logic [WIDTH-1:0] alu_arith_out,
    input  logic [WIDTH-1:0] alu_logic_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_rr_ptr;
    logic             r_owner;
    logic             r_use_logic;
    logic [WIDTH-1:0] r_alu_ra;
    logic [WIDTH-1:0] r_alu_rb;
    logic             r_arith_mode;
    logic             r_logic_alt;
    logic [2:0]       r_funct3;
    logic [WIDTH-1:0] r_rsp_data;
    logic [1:0]       r_rsp_valid;

    logic [1:0]       w_req_valid;
    logic [1:0]       w_req_ready;
    logic [1:0]       w_rsp_ready;
    logic             w_rsp_hs;
    logic             w_arb_en;
    logic             w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [OP_W-1:0]  w_sel_op;

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    // Response handshake: only the owner's ready counts.
    assign w_rsp_hs = (r_state == S_RESP) && w_rsp_ready[r_owner];

    // Arbitration window. Gated by rst_n so no ready is shown during reset.
`ifdef ALU_ARB_PIPE_EN
    assign w_arb_en = rst_n && ((r_state == S_IDLE) || w_rsp_hs);
`else
    assign w_arb_en = rst_n && (r_state == S_IDLE);
`endif

    // Single requester wins outright; a tie goes to the round-robin pointer.
    assign w_grant  = (&w_req_valid) ? r_rr_ptr : w_req_valid[1];
    assign w_accept = w_arb_en && (|w_req_valid);

    assign w_sel_a  = w_grant ? req1_a  : req0_a;
    assign w_sel_b  = w_grant ? req1_b  : req0_b;
    assign w_sel_op = w_grant ? req1_op : req0_op;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign w_req_ready[gi] = w_accept && (w_grant == 1'(gi));
        end
    endgenerate

    assign req0_ready     = w_req_ready[0];
    assign req1_ready     = w_req_ready[1];
    assign rsp0_valid     = r_rsp_valid[0];
    assign rsp1_valid     = r_rsp_valid[1];
    assign rsp0_data      = r_rsp_data;
    assign rsp1_data      = r_rsp_data;
    assign alu_ra         = r_alu_ra;
    assign alu_rb         = r_alu_rb;
    assign alu_arith_mode = r_arith_mode;
    assign alu_logic_alt  = r_logic_alt;
    assign alu_funct3     = r_funct3;

    // Control FSM plus operand, result and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= 1'b0;
            r_owner      <= 1'b0;
            r_use_logic  <= 1'b0;
            r_alu_ra     <= '0;
            r_alu_rb     <= '0;
            r_arith_mode <= 1'b0;
            r_logic_alt  <= 1'b0;
            r_funct3     <= 3'd0;
            r_rsp_data   <= '0;
            r_rsp_valid  <= 2'b00;
        end else begin
            // Accept can only occur in IDLE or on a RESP handoff.
            if (w_accept) begin
                r_alu_ra     <= w_sel_a;
                r_alu_rb     <= w_sel_b;
                r_use_logic  <= w_sel_op[5];
                r_arith_mode <= w_sel_op[4];
                r_logic_alt  <= w_sel_op[3];
                r_funct3     <= w_sel_op[2:0];
                r_owner      <= w_grant;
                r_rr_ptr     <= ~w_grant;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_data           <= r_use_logic ? alu_logic_out : alu_arith_out;
                    r_rsp_valid[r_owner] <= 1'b1;
                    r_state              <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= w_accept ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: table of single-requester ops, a scoreboard
// queue checked by a response monitor, and hand-written sequences for
// round-robin, backpressure, reset mid-operation and throughput.
module tb_alu_arbiter;

    localparam int W = 32;
`ifdef ALU_ARB_PIPE_EN
    localparam int EXP_GAP = 2;
`else
    localparam int EXP_GAP = 3;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [5:0]   req0_op = '0, req1_op = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic [W-1:0] alu_ra, alu_rb;
    logic         alu_arith_mode, alu_logic_alt;
    logic [2:0]   alu_funct3;
    logic [W-1:0] alu_arith_out, alu_logic_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int           sel;
        logic [W-1:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int           sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [5:0]   op;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.WIDTH(W), .OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_ra(alu_ra), .alu_rb(alu_rb),
        .alu_arith_mode(alu_arith_mode), .alu_logic_alt(alu_logic_alt),
        .alu_funct3(alu_funct3),
        .alu_arith_out(alu_arith_out), .alu_logic_out(alu_logic_out)
    );

    // Behavioural ALU fed by the arbiter's registered controls.
    always_comb begin
        alu_arith_out = alu_arith_mode ? (alu_ra - alu_rb) : (alu_ra + alu_rb);
        alu_logic_out = '0;
        case (alu_funct3)
            3'd1: alu_logic_out = alu_ra << alu_rb[4:0];
            3'd2: alu_logic_out = {31'd0, $signed(alu_ra) < $signed(alu_rb)};
            3'd3: alu_logic_out = {31'd0, alu_ra < alu_rb};
            3'd4: alu_logic_out = alu_ra ^ alu_rb;
            3'd5: alu_logic_out = alu_logic_alt ? W'($signed(alu_ra) >>> alu_rb[4:0])
                                                : (alu_ra >> alu_rb[4:0]);
            3'd6: alu_logic_out = alu_ra | alu_rb;
            3'd7: alu_logic_out = alu_ra & alu_rb;
            default: alu_logic_out = alu_ra + alu_rb;
        endcase
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%08h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Response monitor: every handshake pops one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp1_valid)
                check("rsp_exclusive", 32'd1, 32'd0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("rsp_owner", rsp1_valid ? 32'd1 : 32'd0, W'(e.sel));
                    check("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e.exp);
                end
            end
        end
    end

    task automatic drive(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] op, input logic v);
        if (sel == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = v;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = v;
        end
    endtask

    // Wait (bounded) for a ready: sel 0/1 for that requester, 2 for either.
    task automatic wait_ready(input int sel, output int acc);
        acc = -1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if ((sel != 1 && req0_ready) || (sel != 0 && req1_ready)) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("accept_timeout", 32'd1, 32'd0);
    endtask

    // One isolated request: accept, latency to rsp valid, other rsp idle.
    task automatic do_vec(input vec_t v);
        int acc;
        int lat;
        @(posedge clk); #1;
        drive(v.sel, v.a, v.b, v.op, 1'b1);
        wait_ready(v.sel, acc);
        if (acc >= 0) sb_q.push_back('{sel: v.sel, exp: v.exp});
        @(posedge clk); #1;
        drive(v.sel, '0, '0, '0, 1'b0);
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if ((v.sel == 0) ? rsp0_valid : rsp1_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        check("latency", W'(lat), 32'd2);
        check("other_rsp_idle", (v.sel == 0) ? W'(rsp1_valid) : W'(rsp0_valid), 32'd0);
    endtask

    initial begin
        int acc;
        int acc_s[4];
        int who;

        vecs[0] = '{0, 32'd5,          32'd7,  6'b000000, 32'd12};
        vecs[1] = '{1, 32'd10,         32'd3,  6'b010000, 32'd7};
        vecs[2] = '{1, 32'h0000_00F0,  32'h0F, 6'b100100, 32'h0000_00FF};
        vecs[3] = '{1, 32'h8000_0000,  32'd4,  6'b101101, 32'hF800_0000};
        vecs[4] = '{0, 32'h8000_0000,  32'd4,  6'b100101, 32'h0800_0000};
        vecs[5] = '{0, 32'hFFFF_FFFF,  32'd1,  6'b000000, 32'h0000_0000};
        vecs[6] = '{1, 32'hC,          32'hA,  6'b100111, 32'h8};
        vecs[7] = '{0, 32'hC,          32'hA,  6'b100110, 32'hE};
        vecs[8] = '{0, 32'd0,          32'd1,  6'b010000, 32'hFFFF_FFFF};
        vecs[9] = '{1, 32'd1,          32'd31, 6'b100001, 32'h8000_0000};

        // Reset state, with both requests pending during reset.
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req0_ready", W'(req0_ready), 32'd0);
        check("rst_req1_ready", W'(req1_ready), 32'd0);
        check("rst_rsp0_valid", W'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", W'(rsp1_valid), 32'd0);
        check("rst_rsp_data", rsp0_data, 32'd0);
        check("rst_alu_ra", alu_ra, 32'd0);
        check("rst_alu_ctl", {27'd0, alu_arith_mode, alu_logic_alt, alu_funct3}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table of single-requester operations.
        for (int i = 0; i < 10; i++) do_vec(vecs[i]);

        // Round-robin: tie goes to req0, req0 re-presents, req1 goes next.
        @(posedge clk); #1;
        drive(0, 32'd10, 32'd3, 6'b010000, 1'b1);
        drive(1, 32'hF0, 32'h0F, 6'b100100, 1'b1);
        wait_ready(2, acc);
        who = req1_ready ? 1 : 0;
        check("rr_first_grant", W'(who), 32'd0);
        sb_q.push_back('{sel: who, exp: (who == 0) ? 32'd7 : 32'hFF});
        @(posedge clk); #1;
        drive(0, 32'd100, 32'd1, 6'b010000, 1'b1);
        wait_ready(2, acc);
        who = req1_ready ? 1 : 0;
        check("rr_second_grant", W'(who), 32'd1);
        sb_q.push_back('{sel: who, exp: (who == 0) ? 32'd99 : 32'hFF});
        @(posedge clk); #1;
        if (who == 0) drive(0, '0, '0, '0, 1'b0);
        else          drive(1, '0, '0, '0, 1'b0);
        wait_ready(2, acc);
        who = req1_ready ? 1 : 0;
        sb_q.push_back('{sel: who, exp: (who == 0) ? 32'd99 : 32'hFF});
        @(posedge clk); #1;
        drive(0, '0, '0, '0, 1'b0);
        drive(1, '0, '0, '0, 1'b0);
        repeat (4) @(negedge clk);

        // Backpressure on rsp0 with both requesters waiting.
        rsp0_ready = 1'b0;
        do_vec('{0, 32'd20, 32'd22, 6'b000000, 32'd42});
        @(posedge clk); #1;
        drive(0, 32'd1, 32'd1, 6'b000000, 1'b1);
        drive(1, 32'd2, 32'd2, 6'b000000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_rsp0_valid", W'(rsp0_valid), 32'd1);
            check("bp_rsp0_data", rsp0_data, 32'd42);
            check("bp_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        @(posedge clk); #1;
        drive(0, '0, '0, '0, 1'b0);
        drive(1, '0, '0, '0, 1'b0);
        rsp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_cleared", W'(rsp0_valid), 32'd0);

        // Reset during EXEC discards the op and restores rr_ptr to req0.
        @(posedge clk); #1;
        drive(0, 32'd1, 32'd1, 6'b000000, 1'b1);
        wait_ready(0, acc);
        @(posedge clk); #1;
        drive(0, '0, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check("mid_rst_rsp_data", rsp0_data, 32'd0);
        check("mid_rst_alu_ra", alu_ra, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end
        @(posedge clk); #1;
        drive(0, 32'd3, 32'd4, 6'b000000, 1'b1);
        drive(1, 32'hAA, 32'h55, 6'b100100, 1'b1);
        wait_ready(2, acc);
        who = req1_ready ? 1 : 0;
        check("post_rst_grant", W'(who), 32'd0);
        sb_q.push_back('{sel: who, exp: (who == 0) ? 32'd7 : 32'hFF});
        @(posedge clk); #1;
        if (who == 0) drive(0, '0, '0, '0, 1'b0);
        else          drive(1, '0, '0, '0, 1'b0);
        wait_ready(2, acc);
        who = req1_ready ? 1 : 0;
        sb_q.push_back('{sel: who, exp: (who == 0) ? 32'd7 : 32'hFF});
        @(posedge clk); #1;
        drive(0, '0, '0, '0, 1'b0);
        drive(1, '0, '0, '0, 1'b0);
        repeat (4) @(negedge clk);

        // Throughput: req0 streams four ADDs with rsp ready held high.
        @(posedge clk); #1;
        drive(0, 32'd1, 32'd10, 6'b000000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_ready(0, acc_s[k]);
            sb_q.push_back('{sel: 0, exp: W'(11 + k)});
            @(posedge clk); #1;
            if (k < 3) drive(0, W'(k + 2), 32'd10, 6'b000000, 1'b1);
            else       drive(0, '0, '0, '0, 1'b0);
        end
        for (int k = 1; k < 4; k++)
            check("stream_gap", W'(acc_s[k] - acc_s[k-1]), W'(EXP_GAP));
        repeat (5) @(negedge clk);

        check("sb_drained", W'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
